// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the APB multiplexed 7-segment driver.
// Register offsets, brightness ceiling and the active-low hex decoder.
package seg_disp_pkg;

    localparam logic [6:0] OFF_CTRL       = 7'h00;
    localparam logic [6:0] OFF_DIGITS_LO  = 7'h04;
    localparam logic [6:0] OFF_DIGITS_HI  = 7'h08;
    localparam logic [6:0] OFF_DP_MASK    = 7'h0C;
    localparam logic [6:0] OFF_DIG_EN     = 7'h10;
    localparam logic [6:0] OFF_BRIGHT     = 7'h14;
    localparam logic [6:0] OFF_BLINK_MASK = 7'h18;
    localparam logic [6:0] OFF_STATUS     = 7'h1C;

    localparam logic [4:0] BRIGHT_MAX = 5'd16;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan timing: slot prescaler, digit index, frame tick, PWM phase.
// Everything is held at zero while the display is disabled.
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 40000,
    parameter int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic [IW-1:0] scan_idx,
    output logic          frame_tick,
    output logic [3:0]    pwm_cnt
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [PW-1:0] presc;
    logic          slot_tick;

    assign slot_tick  = enable && (presc == PRE_LAST);
    assign frame_tick = slot_tick && (scan_idx == IDX_LAST);

    // Prescaler, digit index and free-running PWM counter.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            presc    <= '0;
            scan_idx <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            presc   <= slot_tick ? '0 : presc + 1'b1;
            if (slot_tick)
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_seg_display_mux.sv
// APB-controlled multiplexed 7-segment driver: registers, blink, pin drive.
// Pins are registered, so they trail the scan state by one clock.
module apb_seg_display_mux
    import seg_disp_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 40000,
    parameter int BLINK_FRAMES = 64,
    parameter int DW           = 32,
    parameter int AW           = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AW-1:0]       pADDR,
    input  logic                pSEL,
    input  logic                pENABLE,
    input  logic                pWRITE,
    input  logic [DW-1:0]       pWDATA,
    output logic [DW-1:0]       pRDATA,
    output logic                pREADY,
    output logic                pSLVERR,
    output logic [N_DIGITS-1:0] anode_select,
    output logic [6:0]          segs,
    output logic                dp
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [63:0] DMASK = (N_DIGITS >= 16) ? {64{1'b1}}
                                  : ((64'd1 << (4 * N_DIGITS)) - 64'd1);
    localparam logic [N_DIGITS-1:0] ONE = 1;

    logic [6:0]          off;
    logic                access, mapped, wr, rd;
    logic                ctrl_en, blink_en;
    logic [63:0]         digits;
    logic [N_DIGITS-1:0] dp_mask, dig_en, blink_mask;
    logic [4:0]          bright;
    logic [BW-1:0]       blink_cnt;
    logic                phase;
    logic [IW-1:0]       scan_idx;
    logic                frame_tick;
    logic [3:0]          pwm_cnt;
    logic [3:0]          nib [N_DIGITS];
    logic                lit;
    logic                unused_addr;

    assign off     = pADDR[6:0];
    assign access  = pSEL & pENABLE & pREADY;
    assign mapped  = (off[1:0] == 2'b00) && (off[6:5] == 2'b00);
    assign wr      = access & pWRITE & mapped;
    assign rd      = access & ~pWRITE & mapped;
    assign pREADY  = 1'b1;
    assign pSLVERR = access & ~mapped;
    assign unused_addr = ^pADDR[AW-1:7];

    seg_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .IW       (IW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .enable     (ctrl_en),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick),
        .pwm_cnt    (pwm_cnt)
    );

    // Register file writes; unmapped and erroring accesses never get here.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_en    <= 1'b0;
            blink_en   <= 1'b0;
            digits     <= '0;
            dp_mask    <= '0;
            dig_en     <= '1;
            bright     <= '0;
            blink_mask <= '0;
        end else if (wr) begin
            case (off)
                OFF_CTRL: begin
                    ctrl_en  <= pWDATA[0];
                    blink_en <= pWDATA[1];
                end
                OFF_DIGITS_LO:  digits[31:0]  <= pWDATA & DMASK[31:0];
                OFF_DIGITS_HI:  digits[63:32] <= pWDATA & DMASK[63:32];
                OFF_DP_MASK:    dp_mask    <= pWDATA[N_DIGITS-1:0];
                OFF_DIG_EN:     dig_en     <= pWDATA[N_DIGITS-1:0];
                OFF_BRIGHT:     bright     <= (pWDATA > DW'(BRIGHT_MAX))
                                              ? BRIGHT_MAX : pWDATA[4:0];
                OFF_BLINK_MASK: blink_mask <= pWDATA[N_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    // Read mux; zero whenever no valid read is in its access phase.
    always_comb begin
        pRDATA = '0;
        if (rd) begin
            case (off)
                OFF_CTRL:       pRDATA = {30'd0, blink_en, ctrl_en};
                OFF_DIGITS_LO:  pRDATA = digits[31:0];
                OFF_DIGITS_HI:  pRDATA = digits[63:32];
                OFF_DP_MASK:    pRDATA = DW'(dp_mask);
                OFF_DIG_EN:     pRDATA = DW'(dig_en);
                OFF_BRIGHT:     pRDATA = DW'(bright);
                OFF_BLINK_MASK: pRDATA = DW'(blink_mask);
                OFF_STATUS:     pRDATA = {23'd0, phase, 4'd0, 4'(scan_idx)};
                default:        pRDATA = '0;
            endcase
        end
    end

    // Blink phase flips after BLINK_FRAMES complete frames.
    always_ff @(posedge clock) begin
        if (reset || !ctrl_en || !blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Unpack the digit register into one nibble per scanned digit.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++)
            nib[i] = digits[4*i +: 4];
    end

    assign lit = ctrl_en & dig_en[scan_idx]
               & ({1'b0, pwm_cnt} < bright)
               & ~(phase & blink_mask[scan_idx]);

    // Registered pin drive; blank whenever the current digit is dark.
    always_ff @(posedge clock) begin
        if (reset || !lit) begin
            anode_select <= '1;
            segs         <= 7'h7F;
            dp           <= 1'b1;
        end else begin
            anode_select <= ~(ONE << scan_idx);
            segs         <= hex7(nib[scan_idx]);
            dp           <= ~dp_mask[scan_idx];
        end
    end

endmodule

// File: tb/tb_apb_seg_display_mux.sv
// Directed bench for apb_seg_display_mux with SCAN_DIV=4, BLINK_FRAMES=2.
// Pins are sampled on the falling edge against a cycle-indexed model.
module tb_apb_seg_display_mux;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pADDR = '0;
    logic        pSEL = 1'b0;
    logic        pENABLE = 1'b0;
    logic        pWRITE = 1'b0;
    logic [31:0] pWDATA = '0;
    logic [31:0] pRDATA;
    logic        pREADY;
    logic        pSLVERR;
    logic [7:0]  anode_select;
    logic [6:0]  segs;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // Configuration mirrored by the expected-value model.
    logic [31:0] m_digits;
    logic [7:0]  m_dig_en, m_dp, m_blink;
    int          m_bright;
    bit          m_blink_en;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    apb_seg_display_mux #(
        .N_DIGITS     (8),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .DW           (32),
        .AW           (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pADDR        (pADDR),
        .pSEL         (pSEL),
        .pENABLE      (pENABLE),
        .pWRITE       (pWRITE),
        .pWDATA       (pWDATA),
        .pRDATA       (pRDATA),
        .pREADY       (pREADY),
        .pSLVERR      (pSLVERR),
        .anode_select (anode_select),
        .segs         (segs),
        .dp           (dp)
    );

    always #5 clock = ~clock;

    // Expected pins produced by scan cycle c (c = 0 is the cycle after enable).
    function automatic void exp_out(input int c, output logic [7:0] a,
                                    output logic [6:0] s, output logic d);
        int idx, pwm, ph;
        bit on;
        a = 8'hFF; s = 7'h7F; d = 1'b1;
        if (c < 0) return;
        idx = (c / 4) % 8;
        pwm = c % 16;
        ph  = m_blink_en ? (c / 64) % 2 : 0;
        on  = m_dig_en[idx] && (pwm < m_bright) && !(ph == 1 && m_blink[idx]);
        if (on) begin
            a = ~(8'h01 << idx);
            s = hex_tab[m_digits[4*idx +: 4]];
            d = ~m_dp[idx];
        end
    endfunction

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                             output logic e);
        @(negedge clock);
        pSEL = 1'b1; pENABLE = 1'b0; pWRITE = 1'b1; pADDR = a; pWDATA = d;
        @(negedge clock);
        pENABLE = 1'b1;
        #1 e = pSLVERR;
        @(posedge clock);
        #1 pSEL = 1'b0; pENABLE = 1'b0; pWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d,
                            output logic e);
        @(negedge clock);
        pSEL = 1'b1; pENABLE = 1'b0; pWRITE = 1'b0; pADDR = a;
        @(negedge clock);
        pENABLE = 1'b1;
        #1 begin d = pRDATA; e = pSLVERR; end
        @(posedge clock);
        #1 pSEL = 1'b0; pENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_reg [8] = '{0, 0, 0, 0, 32'hFF, 0, 0, 0};
        logic [31:0] d;
        logic e;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (anode_select !== 8'hFF || segs !== 7'h7F || dp !== 1'b1
            || pREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_pins: anode=%h segs=%h dp=%b ready=%b want FF 7F 1 1",
                     anode_select, segs, dp, pREADY);
        end
        for (int i = 0; i < 8; i++) begin
            apb_read(32'(i * 4), d, e);
            checks++;
            if (d !== exp_reg[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h err %b want %h err 0",
                         i, d, e, exp_reg[i]);
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] a; logic [6:0] s; logic d; logic e;
        m_digits = 32'h76543210; m_bright = 16; m_dig_en = 8'hFF;
        m_dp = 8'h00; m_blink = 8'h00; m_blink_en = 0;
        apb_write(32'h04, 32'h76543210, e);
        apb_write(32'h14, 32'd16, e);
        apb_write(32'h00, 32'd1, e);
        for (int k = 0; k <= 36; k++) begin
            @(negedge clock);
            exp_out(k - 1, a, s, d);
            checks++;
            if (anode_select !== a || segs !== s || dp !== d) begin
                errors++;
                $display("FAIL scan k=%0d: got %h/%h/%b want %h/%h/%b",
                         k, anode_select, segs, dp, a, s, d);
            end
        end
    endtask

    task automatic test_pwm();
        logic [7:0] a; logic [6:0] s; logic d; logic e;
        logic [31:0] r;
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h14, 32'd4, e);
        m_bright = 4;
        apb_write(32'h00, 32'd1, e);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clock);
            exp_out(k - 1, a, s, d);
            checks++;
            if (anode_select !== a || segs !== s) begin
                errors++;
                $display("FAIL pwm4 k=%0d: got %h/%h want %h/%h",
                         k, anode_select, segs, a, s);
            end
        end
        apb_write(32'h14, 32'd0, e);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            checks++;
            if (anode_select !== 8'hFF) begin
                errors++;
                $display("FAIL pwm0 k=%0d: anode %h want FF", k, anode_select);
            end
        end
        apb_write(32'h14, 32'd31, e);
        apb_read(32'h14, r, e);
        checks++;
        if (r !== 32'd16) begin
            errors++;
            $display("FAIL bright_clamp: got %0d want 16", r);
        end
        apb_write(32'h14, 32'd5, e);
        apb_read(32'h14, r, e);
        checks++;
        if (r !== 32'd5) begin
            errors++;
            $display("FAIL bright_5: got %0d want 5", r);
        end
    endtask

    task automatic test_mask();
        logic [7:0] a; logic [6:0] s; logic d; logic e;
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h14, 32'd16, e);
        apb_write(32'h10, 32'hF0, e);
        apb_write(32'h0C, 32'h11, e);
        m_bright = 16; m_dig_en = 8'hF0; m_dp = 8'h11;
        apb_write(32'h00, 32'd1, e);
        for (int k = 0; k <= 36; k++) begin
            @(negedge clock);
            exp_out(k - 1, a, s, d);
            checks++;
            if (anode_select !== a || segs !== s || dp !== d) begin
                errors++;
                $display("FAIL mask k=%0d: got %h/%h/%b want %h/%h/%b",
                         k, anode_select, segs, dp, a, s, d);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] a; logic [6:0] s; logic d; logic e;
        logic [31:0] r;
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h10, 32'hFF, e);
        apb_write(32'h0C, 32'h00, e);
        apb_write(32'h18, 32'h01, e);
        m_dig_en = 8'hFF; m_dp = 8'h00; m_blink = 8'h01; m_blink_en = 1;
        apb_write(32'h00, 32'd3, e);
        for (int k = 0; k <= 140; k++) begin
            if (k == 71) begin
                apb_read(32'h1C, r, e);
                checks++;
                if (r !== 32'h102) begin
                    errors++;
                    $display("FAIL status_ph1: got %h want 00000102", r);
                end
                k = 72;
                continue;
            end
            @(negedge clock);
            exp_out(k - 1, a, s, d);
            checks++;
            if (anode_select !== a || segs !== s) begin
                errors++;
                $display("FAIL blink k=%0d: got %h/%h want %h/%h",
                         k, anode_select, segs, a, s);
            end
        end
        apb_read(32'h1C, r, e);
        checks++;
        if (r !== 32'h003) begin
            errors++;
            $display("FAIL status_ph0: got %h want 00000003", r);
        end
    endtask

    task automatic test_errors();
        logic [31:0] r;
        logic e;
        apb_write(32'h00, 32'd0, e);
        apb_write(32'h20, 32'hFFFFFFFF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL err_wr20: slverr %b want 1", e);
        end
        apb_write(32'h02, 32'hFFFFFFFF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL err_wr02: slverr %b want 1", e);
        end
        apb_write(32'h46, 32'hFFFFFFFF, e);
        apb_write(32'h44, 32'hFFFFFFFF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL err_wr44: slverr %b want 1", e);
        end
        apb_read(32'h20, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL err_rd20: got %h err %b want 0 err 1", r, e);
        end
        apb_read(32'h02, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL err_rd02: got %h err %b want 0 err 1", r, e);
        end
        apb_read(32'h00, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL err_ctrl_kept: got %h err %b want 0 err 0", r, e);
        end
        apb_read(32'h04, r, e);
        checks++;
        if (r !== 32'h76543210) begin
            errors++; $display("FAIL err_dlo_kept: got %h want 76543210", r);
        end
        apb_read(32'h18, r, e);
        checks++;
        if (r !== 32'h01) begin
            errors++; $display("FAIL err_bmask_kept: got %h want 01", r);
        end
        apb_write(32'h1C, 32'h1FF, e);
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL status_wr: slverr %b want 0", e);
        end
        apb_read(32'h1C, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL status_rd: got %h err %b want 0 err 0", r, e);
        end
        apb_write(32'h08, 32'hFFFFFFFF, e);
        apb_read(32'h08, r, e);
        checks++;
        if (r !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL digits_hi: got %h err %b want 0 err 0", r, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic e;
        apb_write(32'h14, 32'd16, e);
        apb_write(32'h00, 32'd1, e);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (anode_select !== 8'hFF || segs !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pins: got %h/%h/%b want FF/7F/1",
                     anode_select, segs, dp);
        end
        apb_read(32'h1C, r, e);
        checks++;
        if (r !== 32'd0) begin
            errors++; $display("FAIL midreset_status: got %h want 0", r);
        end
        apb_read(32'h10, r, e);
        checks++;
        if (r !== 32'hFF) begin
            errors++; $display("FAIL midreset_digen: got %h want FF", r);
        end
        apb_read(32'h00, r, e);
        checks++;
        if (r !== 32'd0) begin
            errors++; $display("FAIL midreset_ctrl: got %h want 0", r);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pwm();
        test_mask();
        test_blink();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
